// File: rtl/rail_adc_sequencer_if.sv
// rtl/rail_adc_sequencer_if.sv - rail ADC sequencer pin, threshold and result bundle
// The slave side is the sequencer; the master side is the rail pins plus telemetry/fault logic.
interface rail_adc_sequencer_if #(
  parameter int NUMADCS = 5
);
  logic                   enable;
  logic                   start;
  logic [NUMADCS-1:0]     sdat;
  logic [NUMADCS*8-1:0]   th_hi;
  logic [NUMADCS*8-1:0]   th_lo;
  logic                   alarm_clr;
  logic                   cs;
  logic                   mclk;
  logic [NUMADCS*8-1:0]   out_data;
  logic                   data_valid;
  logic                   busy;
  logic [NUMADCS-1:0]     lead_err;
  logic [NUMADCS-1:0]     alarm_hi;
  logic [NUMADCS-1:0]     alarm_lo;

  modport slave (
    input  enable, start, sdat, th_hi, th_lo, alarm_clr,
    output cs, mclk, out_data, data_valid, busy, lead_err, alarm_hi, alarm_lo
  );

  modport master (
    output enable, start, sdat, th_hi, th_lo, alarm_clr,
    input  cs, mclk, out_data, data_valid, busy, lead_err, alarm_hi, alarm_lo
  );
endinterface

// File: rtl/rail_adc_sequencer.sv
// rtl/rail_adc_sequencer.sv - shared cs/mclk scheduler for parallel AD7478 rail-sense ADCs
// Runs one 33-half-period frame per trigger, deserializes every sdat line and checks thresholds.
module rail_adc_sequencer #(
  parameter int SYSCLK_FREQ   = 100_000_000,
  parameter int NUMADCS       = 5,
  parameter int MCLK_DIV      = 5,
  parameter int QUIET_CYCLES  = 10,
  parameter int SAMPLE_PERIOD = 100_000
) (
  input  logic                   sclk,
  input  logic                   rst,
  rail_adc_sequencer_if.slave    bus
);
  localparam int DW = $clog2(MCLK_DIV + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam bit PARAMS_OK = (SYSCLK_FREQ > 0) && (MCLK_DIV >= 1) && (QUIET_CYCLES >= 1) &&
                             (SAMPLE_PERIOD > 33 * MCLK_DIV + QUIET_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, CONVERT, QUIET} state_t;

  state_t                       state_q, state_d;
  logic [DW-1:0]                div_q, div_d;
  logic [5:0]                   half_q, half_d;
  logic [QW-1:0]                quiet_q, quiet_d;
  logic [PW-1:0]                per_q, per_d;
  logic                         pending_q, pending_d;
  logic                         cs_q, cs_d;
  logic                         mclk_q, mclk_d;
  logic [NUMADCS-1:0][11:0]     sr_q, sr_d;
  logic [NUMADCS*8-1:0]         out_q, out_d;
  logic                         dv_q, dv_d;
  logic [NUMADCS-1:0]           lead_q, lead_d;
  logic [NUMADCS-1:0]           ahi_q, ahi_d;
  logic [NUMADCS-1:0]           alo_q, alo_d;
  logic                         tick;
  logic                         trigger;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      half_q    <= '0;
      quiet_q   <= '0;
      per_q     <= '0;
      pending_q <= 1'b0;
      cs_q      <= 1'b1;
      mclk_q    <= 1'b1;
      sr_q      <= '0;
      out_q     <= '0;
      dv_q      <= 1'b0;
      lead_q    <= '0;
      ahi_q     <= '0;
      alo_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      quiet_q   <= quiet_d;
      per_q     <= per_d;
      pending_q <= pending_d;
      cs_q      <= cs_d;
      mclk_q    <= mclk_d;
      sr_q      <= sr_d;
      out_q     <= out_d;
      dv_q      <= dv_d;
      lead_q    <= lead_d;
      ahi_q     <= ahi_d;
      alo_q     <= alo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    quiet_d   = quiet_q;
    pending_d = pending_q;
    cs_d      = cs_q;
    mclk_d    = mclk_q;
    sr_d      = sr_q;
    out_d     = out_q;
    dv_d      = 1'b0;
    lead_d    = lead_q;
    // A set condition later in this block overrides the clear.
    ahi_d     = bus.alarm_clr ? '0 : ahi_q;
    alo_d     = bus.alarm_clr ? '0 : alo_q;
    tick      = bus.enable && (per_q == PW'(SAMPLE_PERIOD - 1));
    per_d     = (bus.enable && !tick) ? per_q + PW'(1) : '0;
    trigger   = bus.start | tick;

    unique case (state_q)
      IDLE: begin
        if (trigger || pending_q) begin
          state_d   = CONVERT;
          pending_d = 1'b0;
          cs_d      = 1'b0;
          mclk_d    = 1'b1;
          div_d     = '0;
          half_d    = '0;
        end
      end
      CONVERT: begin
        if (trigger) pending_d = 1'b1;
        if (div_q == DW'(MCLK_DIV - 1)) begin
          div_d = '0;
          if (half_q == 6'd32) begin
            state_d = QUIET;
            quiet_d = '0;
            cs_d    = 1'b1;
            mclk_d  = 1'b1;
            dv_d    = 1'b1;
            for (int i = 0; i < NUMADCS; i++) begin
              out_d[8*i +: 8] = sr_q[i][7:0];
              lead_d[i]       = |sr_q[i][11:8];
              if (sr_q[i][7:0] > bus.th_hi[8*i +: 8]) ahi_d[i] = 1'b1;
              if (sr_q[i][7:0] < bus.th_lo[8*i +: 8]) alo_d[i] = 1'b1;
            end
          end else begin
            half_d = half_q + 6'd1;
            // Odd halves are low, so leaving an odd half is an mclk rise; rises 1..12 end at half 23.
            mclk_d = half_q[0];
            if (half_q[0] && half_q <= 6'd23) begin
              for (int i = 0; i < NUMADCS; i++) sr_d[i] = {sr_q[i][10:0], bus.sdat[i]};
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      QUIET: begin
        if (trigger) pending_d = 1'b1;
        if (quiet_q == QW'(QUIET_CYCLES)) state_d = IDLE;
        else quiet_d = quiet_q + QW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cs         = cs_q;
  assign bus.mclk       = mclk_q;
  assign bus.out_data   = out_q;
  assign bus.data_valid = dv_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.lead_err   = lead_q;
  assign bus.alarm_hi   = ahi_q;
  assign bus.alarm_lo   = alo_q;

  params_ok_a: assert property (@(posedge sclk) PARAMS_OK);
endmodule

// File: tb/tb_rail_adc_sequencer.sv
// tb/tb_rail_adc_sequencer.sv - directed self-checking bench for rail_adc_sequencer
module tb_rail_adc_sequencer;
  localparam int N   = 5;
  localparam int DIV = 5;
  localparam int QC  = 10;
  localparam int SP  = 1000;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  int   rises_m = 0;
  logic [15:0] word [N];

  rail_adc_sequencer_if #(.NUMADCS(N)) bus ();

  rail_adc_sequencer #(
    .SYSCLK_FREQ(100_000_000), .NUMADCS(N), .MCLK_DIV(DIV),
    .QUIET_CYCLES(QC), .SAMPLE_PERIOD(SP)
  ) dut (
    .sclk(sclk), .rst(rst), .bus(bus)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc++;

  // ADC model: bit for rise k is presented before rise k, advancing after each mclk rise.
  always @(posedge bus.mclk or posedge bus.cs) begin
    if (bus.cs) rises_m = 0;
    else rises_m++;
  end

  always_comb begin
    bus.sdat = '0;
    for (int i = 0; i < N; i++) bus.sdat[i] = (rises_m < 16) ? word[i][15 - rises_m] : 1'b0;
  end

  task automatic set_words(input logic [15:0] w);
    for (int i = 0; i < N; i++) word[i] = w;
  endtask

  task automatic wait_dv(output int t, input int budget);
    int k = 0;
    while (!bus.data_valid && k < budget) begin @(negedge sclk); k++; end
    t = bus.data_valid ? cyc : -1;
    @(negedge sclk);
  endtask

  task automatic wait_cs_low(output int t, input int budget);
    int k = 0;
    while (bus.cs && k < budget) begin @(negedge sclk); k++; end
    t = !bus.cs ? cyc : -1;
    @(negedge sclk);
  endtask

  task automatic run_frame(output int cs_low, output int nrise, output int ndv, output int dv_edge);
    logic pc, pm;
    cs_low = 0; nrise = 0; ndv = 0; dv_edge = 0; pc = 1'b1; pm = 1'b1;
    @(negedge sclk) bus.start = 1'b1;
    @(negedge sclk) bus.start = 1'b0;
    for (int k = 0; k < 250; k++) begin
      if (!bus.cs) cs_low++;
      if (bus.mclk && !pm && !bus.cs) nrise++;
      if (bus.data_valid) begin
        ndv++;
        if (bus.cs && !pc) dv_edge++;
      end
      pc = bus.cs; pm = bus.mclk;
      @(negedge sclk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge sclk);
    @(negedge sclk) rst = 1'b0;
    @(negedge sclk);
    ntests++; if (bus.cs !== 1'b1) begin nfail++; $display("FAIL reset_cs: got %b want 1", bus.cs); end
    ntests++; if (bus.mclk !== 1'b1) begin nfail++; $display("FAIL reset_mclk: got %b want 1", bus.mclk); end
    ntests++; if (bus.out_data !== '0) begin nfail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    ntests++; if ({bus.alarm_hi, bus.alarm_lo} !== '0) begin nfail++; $display("FAIL reset_alarms: got %b_%b want 0", bus.alarm_hi, bus.alarm_lo); end
    ntests++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    ntests++; if (bus.data_valid !== 1'b0) begin nfail++; $display("FAIL reset_dv: got %b want 0", bus.data_valid); end
  endtask

  task automatic test_oneshot;
    int cl, nr, nd, de;
    bus.enable = 1'b0;
    set_words(16'h0A50);
    run_frame(cl, nr, nd, de);
    ntests++; if (cl != 165) begin nfail++; $display("FAIL oneshot_cs_low: got %0d want 165", cl); end
    ntests++; if (nr != 16) begin nfail++; $display("FAIL oneshot_rises: got %0d want 16", nr); end
    ntests++; if (nd != 1) begin nfail++; $display("FAIL oneshot_dv_count: got %0d want 1", nd); end
    ntests++; if (de != 1) begin nfail++; $display("FAIL oneshot_dv_at_cs_rise: got %0d want 1", de); end
    ntests++; if (bus.out_data !== {N{8'hA5}}) begin nfail++; $display("FAIL oneshot_data: got %h want %h", bus.out_data, {N{8'hA5}}); end
    ntests++; if (bus.lead_err !== '0) begin nfail++; $display("FAIL oneshot_lead_err: got %b want 0", bus.lead_err); end
    ntests++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL oneshot_idle_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_periodic;
    int t1, t2, t3, tc, tx;
    @(negedge sclk) bus.enable = 1'b1;
    wait_dv(t1, 1200);
    wait_dv(t2, 1200);
    wait_dv(t3, 1200);
    ntests++; if (t1 < 0 || t2 - t1 != 1000) begin nfail++; $display("FAIL periodic_gap1: got %0d want 1000", t2 - t1); end
    ntests++; if (t2 < 0 || t3 - t2 != 1000) begin nfail++; $display("FAIL periodic_gap2: got %0d want 1000", t3 - t2); end
    wait_cs_low(tc, 1200);
    repeat (40) @(negedge sclk);
    bus.enable = 1'b0;
    wait_dv(tx, 300);
    ntests++; if (tc < 0 || tx < 0) begin nfail++; $display("FAIL periodic_disable_completes: got dv=%0d want frame end", tx); end
    wait_cs_low(tx, 2500);
    ntests++; if (tx != -1) begin nfail++; $display("FAIL periodic_disable_stops: got frame at %0d want none", tx); end
  endtask

  task automatic test_collision;
    int t0, t1, t2, t3, t4;
    @(negedge sclk) bus.start = 1'b1;
    @(negedge sclk) bus.start = 1'b0;
    wait_cs_low(t0, 5);
    for (int p = 0; p < 3; p++) begin
      repeat (10) @(negedge sclk);
      bus.start = 1'b1;
      @(negedge sclk) bus.start = 1'b0;
    end
    wait_dv(t1, 300);
    wait_cs_low(t2, 100);
    ntests++; if (t0 < 0 || t1 < 0 || t2 < 0 || t2 - t1 != QC + 2) begin nfail++; $display("FAIL collision_restart_gap: got %0d want %0d", t2 - t1, QC + 2); end
    wait_dv(t3, 300);
    ntests++; if (t3 < 0) begin nfail++; $display("FAIL collision_second_dv: got none want pulse"); end
    wait_cs_low(t4, 500);
    ntests++; if (t4 != -1) begin nfail++; $display("FAIL collision_single_extra: got frame at %0d want none", t4); end
  endtask

  task automatic test_alarms;
    int t;
    bus.th_hi = {N{8'h80}};
    bus.th_lo = {N{8'h10}};
    word[0] = 16'h0810; word[1] = 16'h00F0; word[2] = 16'h4800; word[3] = 16'h0400; word[4] = 16'h0400;
    @(negedge sclk) bus.alarm_clr = 1'b1;
    @(negedge sclk) bus.alarm_clr = 1'b0;
    ntests++; if ({bus.alarm_hi, bus.alarm_lo} !== '0) begin nfail++; $display("FAIL alarm_clear: got %b_%b want 0", bus.alarm_hi, bus.alarm_lo); end
    bus.start = 1'b1;
    @(negedge sclk) bus.start = 1'b0;
    t = 0;
    while (!bus.data_valid && t < 300) begin @(negedge sclk); t++; end
    ntests++; if (bus.alarm_hi !== 5'b00001) begin nfail++; $display("FAIL alarm_hi: got %b want 00001", bus.alarm_hi); end
    ntests++; if (bus.alarm_lo !== 5'b00010) begin nfail++; $display("FAIL alarm_lo: got %b want 00010", bus.alarm_lo); end
    ntests++; if (bus.lead_err !== 5'b00100) begin nfail++; $display("FAIL lead_err: got %b want 00100", bus.lead_err); end
    ntests++; if (bus.out_data[23:0] !== 24'h800F81) begin nfail++; $display("FAIL alarm_data: got %h want 800f81", bus.out_data[23:0]); end
    repeat (20) @(negedge sclk);
    bus.alarm_clr = 1'b1;
    bus.start = 1'b1;
    @(negedge sclk) bus.start = 1'b0;
    t = 0;
    while (!bus.data_valid && t < 300) begin @(negedge sclk); t++; end
    bus.alarm_clr = 1'b0;
    repeat (3) @(negedge sclk);
    ntests++; if (bus.alarm_hi !== 5'b00001 || bus.alarm_lo !== 5'b00010) begin nfail++; $display("FAIL alarm_set_wins: got %b_%b want 00001_00010", bus.alarm_hi, bus.alarm_lo); end
    repeat (20) @(negedge sclk);
  endtask

  task automatic test_reset_midframe;
    int nr, ndv, cl, nd, de;
    logic pm;
    set_words(16'h0A50);
    @(negedge sclk) bus.start = 1'b1;
    @(negedge sclk) bus.start = 1'b0;
    nr = 0; pm = 1'b1;
    for (int k = 0; k < 300 && nr < 8; k++) begin
      if (bus.mclk && !pm && !bus.cs) nr++;
      pm = bus.mclk;
      if (nr < 8) @(negedge sclk);
    end
    rst = 1'b1;
    #1;
    ntests++; if (nr != 8 || bus.cs !== 1'b1) begin nfail++; $display("FAIL midreset_cs_async: got cs=%b rises=%0d want cs=1 rises=8", bus.cs, nr); end
    ntests++; if (bus.out_data !== '0) begin nfail++; $display("FAIL midreset_out_data: got %h want 0", bus.out_data); end
    ndv = 0;
    repeat (2) @(negedge sclk);
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.data_valid) ndv++;
      @(negedge sclk);
    end
    ntests++; if (ndv != 0) begin nfail++; $display("FAIL midreset_no_dv: got %0d want 0", ndv); end
    run_frame(cl, nr, nd, de);
    ntests++; if (cl != 165 || nd != 1) begin nfail++; $display("FAIL midreset_clean_frame: got cs_low=%0d dv=%0d want 165/1", cl, nd); end
    ntests++; if (bus.out_data !== {N{8'hA5}}) begin nfail++; $display("FAIL midreset_data: got %h want %h", bus.out_data, {N{8'hA5}}); end
  endtask

  initial begin
    bus.enable = 1'b0; bus.start = 1'b0; bus.alarm_clr = 1'b0;
    bus.th_hi = {N{8'hFF}}; bus.th_lo = '0;
    set_words(16'h0000);
    test_reset;
    test_oneshot;
    test_periodic;
    test_collision;
    test_alarms;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
